lde_bank_arbiter: RTL and testbench

Sequences and shares a bank of NLAT transparent-low D-latches with gate enable (LDE_1-style: transparent while gate is low and enable is high) among NREQ requesters. A round-robin arbiter picks one write request. A state machine then drives the shared latch data bus, the per-latch one-hot gate enables and the shared active-low gate, using defined setup, open and hold phases. Sits between synchronous register-write masters and a latch-based storage bank, so no requester ever touches the latch gates directly.

---
 rtl/lde_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_lde_bank_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lde_bank_arbiter.sv
// Round-robin write arbiter in front of a bank of transparent-low gated latches.
// Each granted write runs SETUP -> OPEN -> HOLD so data and enables are stable around the gate pulse.
module lde_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int NLAT     = 8,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic              C,
  input  logic              CLR_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   ACK,
  output logic              ERR,
  output logic              BUSY,
  output logic [DW-1:0]     LAT_D,
  output logic              LAT_G,
  output logic [NLAT-1:0]   LAT_GE,
  output logic [1:0]        STATE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int PW   = $clog2(NREQ);
  localparam int MAXC = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_q;
  logic            oor_q;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] elig;
  logic [PW:0]     cand;
  logic [PW-1:0]   arb_idx;
  logic            arb_hit;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_in_range;
  logic [NLAT-1:0] sel_ge;
  logic [NREQ-1:0] sel_gnt;

  // The requester being acknowledged this cycle sits out one arbitration round.
  assign elig = REQ & ~ACK;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (elig[cand[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr     = REQ_ADDR[int'(arb_idx)*AW +: AW];
    sel_data     = REQ_DATA[int'(arb_idx)*DW +: DW];
    sel_in_range = (int'(sel_addr) < NLAT);
    sel_gnt      = '0;
    sel_gnt[arb_idx] = 1'b1;
    sel_ge       = '0;
    for (int j = 0; j < NLAT; j++) begin
      sel_ge[j] = (int'(sel_addr) == j);
    end
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= S_IDLE;
      ptr    <= '0;
      win_q  <= '0;
      oor_q  <= 1'b0;
      cnt    <= '0;
      GNT    <= '0;
      ACK    <= '0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
      LAT_D  <= '0;
      LAT_G  <= 1'b1;
      LAT_GE <= '0;
    end else begin
      ACK <= '0;
      ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_hit) begin
            state  <= S_SETUP;
            win_q  <= arb_idx;
            oor_q  <= !sel_in_range;
            GNT    <= sel_gnt;
            LAT_D  <= sel_data;
            LAT_GE <= sel_ge;
            BUSY   <= 1'b1;
          end
        end
        S_SETUP: begin
          state <= S_OPEN;
          LAT_G <= 1'b0;
          cnt   <= CW'(OPEN_CYC - 1);
        end
        S_OPEN: begin
          if (cnt == '0) begin
            state <= S_HOLD;
            LAT_G <= 1'b1;
            cnt   <= CW'(HOLD_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            // LAT_D is left as-is; only the enables and grant are withdrawn.
            state  <= S_IDLE;
            ACK    <= GNT;
            ERR    <= oor_q;
            GNT    <= '0;
            LAT_GE <= '0;
            BUSY   <= 1'b0;
            ptr    <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_lde_bank_arbiter.sv
// Directed bench for lde_bank_arbiter: drivers push expected grants/acks into queues,
// a negedge monitor pops and compares them and checks every gate pulse.
module tb_lde_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NLAT = 6;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int OPEN_CYC = 2;
  localparam int HOLD_CYC = 1;

  logic              C = 1'b0;
  logic              CLR_N = 1'b1;
  logic [NREQ-1:0]   REQ = '0;
  logic [NREQ*AW-1:0] REQ_ADDR = '0;
  logic [NREQ*DW-1:0] REQ_DATA = '0;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   ACK;
  logic              ERR;
  logic              BUSY;
  logic [DW-1:0]     LAT_D;
  logic              LAT_G;
  logic [NLAT-1:0]   LAT_GE;
  logic [1:0]        STATE;

  lde_bank_arbiter #(
    .NREQ(NREQ), .NLAT(NLAT), .AW(AW), .DW(DW),
    .OPEN_CYC(OPEN_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .C(C), .CLR_N(CLR_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .LAT_D(LAT_D),
    .LAT_G(LAT_G), .LAT_GE(LAT_GE), .STATE(STATE)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_mis = 0;
  int exp_pulses = 0;
  int seen_pulses = 0;

  // gnt entry: {cycle[15:0], gnt[3:0], lat_d[7:0], lat_ge[5:0]}
  logic [33:0] gnt_q[$];
  // ack entry: {cycle[15:0], ack[3:0], err}
  logic [20:0] ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int c, input logic [3:0] g, input logic [7:0] d, input logic [5:0] ge);
    gnt_q.push_back({16'(c), g, d, ge});
  endtask

  task automatic push_ack(input int c, input logic [3:0] a, input logic e);
    ack_q.push_back({16'(c), a, e});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
    REQ[i] = 1'b1;
    REQ_ADDR[i*AW +: AW] = a;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  // ---------------- monitor ----------------
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_g = 1'b1;
  int              low_run = 0;
  int              rise_cyc = 0;
  logic [7:0]      exp_d = '0;
  logic [5:0]      exp_ge = '0;

  always @(negedge C) begin
    if (!CLR_N) begin
      prev_gnt = '0;
      prev_g   = 1'b1;
      low_run  = 0;
    end else begin
      if (GNT != '0 && prev_gnt == '0) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(GNT), 32'(0));
        end else begin
          logic [33:0] e;
          e = gnt_q.pop_front();
          check("gnt_cycle", 32'(cyc[15:0]), 32'(e[33:18]));
          check("gnt_value", 32'(GNT), 32'(e[17:14]));
          check("gnt_lat_d", 32'(LAT_D), 32'(e[13:6]));
          check("gnt_lat_ge", 32'(LAT_GE), 32'(e[5:0]));
          check("gnt_lat_g_high", 32'(LAT_G), 32'(1));
          check("gnt_busy", 32'(BUSY), 32'(1));
          exp_d    = e[13:6];
          exp_ge   = e[5:0];
          rise_cyc = cyc;
        end
      end
      if (!LAT_G) begin
        if (prev_g) check("gate_fall_cycle", 32'(cyc), 32'(rise_cyc + 1));
        low_run++;
        check("open_lat_d", 32'(LAT_D), 32'(exp_d));
        check("open_lat_ge", 32'(LAT_GE), 32'(exp_ge));
      end else if (!prev_g) begin
        check("gate_low_len", 32'(low_run), 32'(OPEN_CYC));
        seen_pulses++;
        low_run = 0;
      end
      if (ACK != '0 || ERR) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 32'({ACK, ERR}), 32'(0));
        end else begin
          logic [20:0] a;
          a = ack_q.pop_front();
          check("ack_cycle", 32'(cyc[15:0]), 32'(a[20:5]));
          check("ack_value", 32'(ACK), 32'(a[4:1]));
          check("ack_err", 32'(ERR), 32'(a[0]));
          check("ack_gnt_clear", 32'(GNT), 32'(0));
          check("ack_lat_ge_clear", 32'(LAT_GE), 32'(0));
        end
      end
      prev_gnt = GNT;
      prev_g   = LAT_G;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;

    // Reset values
    #1 CLR_N = 1'b0;
    #2;
    check("rst_lat_g", 32'(LAT_G), 32'(1));
    check("rst_lat_ge", 32'(LAT_GE), 32'(0));
    check("rst_lat_d", 32'(LAT_D), 32'(0));
    check("rst_gnt", 32'(GNT), 32'(0));
    check("rst_ack", 32'(ACK), 32'(0));
    check("rst_err", 32'(ERR), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    repeat (2) @(posedge C);
    #2 CLR_N = 1'b1;
    step(1);

    // Single write: r0 addr 5 data A5 (pointer 0 -> 1)
    c = cyc;
    set_req(0, 3'd5, 8'hA5);
    push_gnt(c + 1, 4'b0001, 8'hA5, 6'h20);
    push_ack(c + 5, 4'b0001, 1'b0);
    exp_pulses++;
    step(1);
    REQ = '0;
    step(7);

    // Out-of-range: r2 addr 7 with NLAT=6 (pointer 1 -> 3)
    c = cyc;
    set_req(2, 3'd7, 8'h77);
    push_gnt(c + 1, 4'b0100, 8'h77, 6'h00);
    push_ack(c + 5, 4'b0100, 1'b1);
    exp_pulses++;
    step(1);
    REQ = '0;
    step(7);

    // Input change after grant: r1 data 11 -> 22 and REQ drop at cycle 2 (pointer 3 -> 2)
    c = cyc;
    set_req(1, 3'd3, 8'h11);
    push_gnt(c + 1, 4'b0010, 8'h11, 6'h08);
    push_ack(c + 5, 4'b0010, 1'b0);
    exp_pulses++;
    step(2);
    REQ_DATA[1*DW +: DW] = 8'h22;
    REQ = '0;
    step(6);

    // Sole held requester r1: masked in its ACK cycle, re-arbitrated the cycle after
    c = cyc;
    set_req(1, 3'd1, 8'h5A);
    push_gnt(c + 1,  4'b0010, 8'h5A, 6'h02);
    push_ack(c + 5,  4'b0010, 1'b0);
    push_gnt(c + 7,  4'b0010, 8'h5A, 6'h02);
    push_ack(c + 11, 4'b0010, 1'b0);
    push_gnt(c + 13, 4'b0010, 8'h5A, 6'h02);
    push_ack(c + 17, 4'b0010, 1'b0);
    exp_pulses += 3;
    step(13);
    REQ = '0;
    step(6);

    // Reset mid-OPEN: r3 granted, reset during cycle 3, no ACK
    c = cyc;
    set_req(3, 3'd4, 8'h3C);
    push_gnt(c + 1, 4'b1000, 8'h3C, 6'h10);
    step(1);
    REQ = '0;
    repeat (2) @(posedge C);
    #1;
    check("open_before_reset", 32'(LAT_G), 32'(0));
    #1 CLR_N = 1'b0;
    #1;
    check("midrst_lat_g", 32'(LAT_G), 32'(1));
    check("midrst_lat_ge", 32'(LAT_GE), 32'(0));
    check("midrst_gnt", 32'(GNT), 32'(0));
    check("midrst_busy", 32'(BUSY), 32'(0));
    repeat (2) @(posedge C);
    #2 CLR_N = 1'b1;
    step(2);

    // Contention after reset: all four held, order 0,1,2,3,0
    c = cyc;
    set_req(0, 3'd0, 8'h10);
    set_req(1, 3'd1, 8'h21);
    set_req(2, 3'd2, 8'h32);
    set_req(3, 3'd3, 8'h43);
    push_gnt(c + 1,  4'b0001, 8'h10, 6'h01);
    push_ack(c + 5,  4'b0001, 1'b0);
    push_gnt(c + 6,  4'b0010, 8'h21, 6'h02);
    push_ack(c + 10, 4'b0010, 1'b0);
    push_gnt(c + 11, 4'b0100, 8'h32, 6'h04);
    push_ack(c + 15, 4'b0100, 1'b0);
    push_gnt(c + 16, 4'b1000, 8'h43, 6'h08);
    push_ack(c + 20, 4'b1000, 1'b0);
    push_gnt(c + 21, 4'b0001, 8'h10, 6'h01);
    push_ack(c + 25, 4'b0001, 1'b0);
    exp_pulses += 5;
    step(21);
    REQ = '0;
    step(8);

    // Drain and final accounting
    for (int t = 0; t < 40 && (gnt_q.size() != 0 || ack_q.size() != 0); t++) step(1);
    check("gnt_q_empty", 32'(gnt_q.size()), 32'(0));
    check("ack_q_empty", 32'(ack_q.size()), 32'(0));
    check("gate_pulses", 32'(seen_pulses), 32'(exp_pulses));
    check("final_idle", 32'(BUSY), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
